// File: rtl/counter_6bit.sv
// Free-running modulo-(MAX_VAL+1) address counter with terminal-count decode
// and a 2-bit wrap counter (sine quadrant index with the default parameters).
module counter_6bit #(
  parameter int WIDTH    = 6,
  parameter int MAX_VAL  = 63,
  parameter int INIT_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] par_out,
  output logic             tc,
  output logic [1:0]       wrap_cnt
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT_VAL);

  logic [WIDTH-1:0] r_count;
  logic [1:0]       r_wrap;
  logic             w_at_max;

  // Wrap decision uses >= so that no value above MAX_VAL can ever persist,
  // and the increment never relies on native WIDTH-bit overflow.
  function automatic logic at_or_above_max(input logic [WIDTH-1:0] cnt);
    return (cnt >= MAX_C);
  endfunction

  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cnt);
    if (at_or_above_max(cnt)) begin
      return '0;
    end
    return cnt + WIDTH'(1);
  endfunction

  assign w_at_max = at_or_above_max(r_count);

  // Stage: count and wrap registers; reset wins over a coincident wrap
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= INIT_C;
      r_wrap  <= 2'd0;
    end else begin
      r_count <= next_count(r_count);
      if (w_at_max) begin
        r_wrap <= r_wrap + 2'd1;
      end
    end
  end

  assign par_out  = r_count;
  assign tc       = (r_count == MAX_C);
  assign wrap_cnt = r_wrap;

endmodule

// File: tb/tb_counter_6bit.sv
// Scoreboard bench for counter_6bit: default instance and a MAX_VAL=9/INIT_VAL=3
// instance share one reset; expectations come from an edges-since-reset model.
module tb_counter_6bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] par_a;
  logic       tc_a;
  logic [1:0] wrap_a;
  logic [3:0] par_b;
  logic       tc_b;
  logic [1:0] wrap_b;

  counter_6bit dut_a (
    .clk(clk), .rst(rst), .par_out(par_a), .tc(tc_a), .wrap_cnt(wrap_a)
  );

  counter_6bit #(.WIDTH(4), .MAX_VAL(9), .INIT_VAL(3)) dut_b (
    .clk(clk), .rst(rst), .par_out(par_b), .tc(tc_b), .wrap_cnt(wrap_b)
  );

  typedef struct {
    int par;
    bit tc;
    int wrap;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = 0;   // rising edges with rst high since the last reset edge

  // Position after k edges from INIT is INIT+k along an unbounded line;
  // the count is that modulo the period, the wrap index its quotient mod 4.
  function automatic exp_t model(input int maxv, input int init, input int kk);
    exp_t e;
    int   v;
    v      = init + kk;
    e.par  = v % (maxv + 1);
    e.tc   = (e.par == maxv);
    e.wrap = (v / (maxv + 1)) % 4;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  task automatic check_all(input string nm, input logic [15:0] ap, input logic at,
                           input logic [1:0] aw, input exp_t e);
    cmp({nm, ".par_out"},  ap,          16'(e.par));
    cmp({nm, ".tc"},       {15'd0, at}, {15'd0, e.tc});
    cmp({nm, ".wrap_cnt"}, {14'd0, aw}, 16'(e.wrap));
  endtask

  task automatic push_expected();
    qa.push_back(model(63, 0, k));
    qb.push_back(model(9, 3, k));
  endtask

  task automatic step(input bit r);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    if (!r) k = 0;
    else    k = k + 1;
    push_expected();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_all("A", {10'd0, par_a}, tc_a, wrap_a, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_all("B", {12'd0, par_b}, tc_b, wrap_b, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    // Reset two cycles, then five counting edges
    step(1'b0);
    step(1'b0);
    run(5);

    // Full sweep to terminal count and first wrap
    step(1'b0);
    run(64);

    // Four sweeps: wrap index 1,2,3,0
    step(1'b0);
    run(256);

    // Asynchronous-looking reset request at count 37 must wait for the edge
    step(1'b0);
    run(37);
    @(negedge clk);
    rst = 1'b0;
    #1;
    e = model(63, 0, k);
    cmp("midcycle.A.par_out", {10'd0, par_a}, 16'(e.par));
    cmp("midcycle.A.wrap_cnt", {14'd0, wrap_a}, 16'(e.wrap));
    e = model(9, 3, k);
    cmp("midcycle.B.par_out", {12'd0, par_b}, 16'(e.par));
    @(posedge clk);
    k = 0;
    push_expected();

    // Reset coinciding with the wrap edge at 63
    step(1'b0);
    run(63);
    step(1'b0);
    step(1'b0);
    run(3);

    // Randomized run with sporadic reset pulses
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1);
    end

    @(posedge clk);
    @(posedge clk);
    #3;
    cmp("scoreboard.drained", 16'(qa.size() + qb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_6bit.md
COUNTER_6BIT -- requirements
Module: counter_6bit

Interface
REQ-001 Parameter WIDTH, default 6, counter width in bits; SHALL be 1..16.
REQ-002 Parameter MAX_VAL, default 63, terminal value; SHALL satisfy 0 < MAX_VAL <= 2^WIDTH-1.
REQ-003 Parameter INIT_VAL, default 0, value loaded on reset; SHALL satisfy INIT_VAL <= MAX_VAL.
REQ-004 Ports SHALL be, in this order:
- clk  input  1  rising-edge clock, sole clock.
- rst  input  1  reset; one clock; synchronous, active-low.
- par_out  output  WIDTH  current count, registered.
- tc  output  1  terminal count, high while par_out == MAX_VAL, combinational decode of par_out.
- wrap_cnt  output  2  number of wraps modulo 4, registered.
REQ-005 tc and wrap_cnt SHALL be optional to connect; operation with only clk, rst and par_out connected SHALL be fully defined.

Function
REQ-006 All state SHALL change only on the rising edge of clk.
REQ-007 When rst is low at a rising edge: par_out SHALL become INIT_VAL and wrap_cnt SHALL become 0.
REQ-008 When rst is high at a rising edge and par_out < MAX_VAL: par_out SHALL become par_out+1.
REQ-009 When rst is high at a rising edge and par_out == MAX_VAL: par_out SHALL become 0 and wrap_cnt SHALL become wrap_cnt+1 modulo 4 (3 -> 0).
REQ-010 wrap_cnt SHALL hold its value on every non-wrapping edge.
REQ-011 par_out SHALL count every clock with no enable; latency from reset release to first increment SHALL be one edge (rst high at edge N gives INIT_VAL+1 after edge N).
REQ-012 tc SHALL be high for exactly one clock per period of MAX_VAL+1 cycles, in the cycle before wrap.
REQ-013 The count sequence SHALL be 0,1,...,MAX_VAL,0,...; values above MAX_VAL SHALL never appear.
REQ-014 Arithmetic SHALL be unsigned WIDTH-bit, with no dependence on native overflow when MAX_VAL < 2^WIDTH-1.
REQ-015 Reset SHALL take priority over a coincident wrap; neither wrap_cnt nor par_out SHALL advance on that edge.
REQ-016 Outputs SHALL contain no X/Z after the first reset edge.
REQ-017 With defaults, wrap_cnt SHALL give the sine quadrant: 0,1,2,3 for successive 64-cycle address sweeps.

Reset
REQ-018 Reset SHALL be synchronous: asserting rst low between edges SHALL NOT change outputs until the next rising edge.
REQ-019 Reset mid-count (e.g., par_out=37) SHALL return par_out to INIT_VAL and wrap_cnt to 0 at the next edge.
REQ-020 Holding rst low for multiple cycles SHALL hold par_out=INIT_VAL, wrap_cnt=0, with tc low unless INIT_VAL == MAX_VAL.
REQ-021 Before the first reset edge, output values are unspecified; the bench SHALL apply reset first.

Verification
REQ-022 The bench SHALL cover these directed scenarios (defaults unless stated):
- rst low 2 cycles, then high 5 edges -> par_out 0 during reset, then 1,2,3,4,5; wrap_cnt 0.
- Run 64 edges from 0 -> par_out reaches 63 with tc=1, next edge par_out=0, wrap_cnt=1, tc=0.
- Run 256 edges from reset -> wrap_cnt sequence 1,2,3,0, par_out back to 0.
- rst driven low at par_out=37, mid-cycle -> no change until next edge, then par_out=0, wrap_cnt=0.
- rst low on the edge where par_out=63 -> par_out=0, wrap_cnt unchanged at 0 (no increment).
- MAX_VAL=9, INIT_VAL=3 -> reset gives 3; sequence 4..9,0,1...; tc high only at 9; never exceeds 9.
